// File: rtl/math_game_ctrl.sv
// math_game_ctrl
//   Controller for a two-operand addition quiz. Each round shows operand A,
//   then operand B, then waits for the player to enter the sum on the
//   switches and press submit. The result is shown for a while, then the
//   next round starts. After ROUNDS rounds the final score is displayed.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       level; begins a game from IDLE or DONE
//   submit      answer button; only its rising edge is acted on
//   switch[7:0] player's binary answer
//   lfsr_in[4:0] operand source (free-running LFSR, 1..31)
//   disp_value[7:0] binary value for the BCD converter (registered)
//   led[6:0]    status LEDs (registered)
//   score[3:0]  correct answers in the current game (registered)
//   state[2:0]  current FSM state
//
// Configuration
//   MATH_GAME_TIMEOUT_EN  when defined, WAIT_ANS gives up after
//                         TIMEOUT_CYCLES cycles and scores the round wrong.
//                         When undefined, no window counter exists.

module math_game_ctrl #(
    parameter int SHOW_CYCLES    = 50_000_000,
    parameter int RESULT_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int ROUNDS         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       submit,
    input  logic [7:0] switch,
    input  logic [4:0] lfsr_in,
    output logic [7:0] disp_value,
    output logic [6:0] led,
    output logic [3:0] score,
    output logic [2:0] state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_SHOW_A = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_SHOW_B = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_RESULT = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

    // An out-of-range configuration falls back to single-round play rather
    // than producing a round counter that can never match.
    localparam bit CFG_OK = (ROUNDS >= 1) && (ROUNDS <= 15) && (SHOW_CYCLES >= 1)
                            && (RESULT_CYCLES >= 1) && (TIMEOUT_CYCLES >= 1);
    localparam logic [3:0] ROUNDS_L = CFG_OK ? 4'(ROUNDS) : 4'd1;

    // One counter serves both display phases; they never overlap.
    localparam int HOLD_MAX = (SHOW_CYCLES > RESULT_CYCLES) ? SHOW_CYCLES : RESULT_CYCLES;
    localparam int CNT_W    = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX);
    localparam logic [CNT_W-1:0] SHOW_LAST   = CNT_W'(SHOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'(RESULT_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [3:0]       score_q, score_d;
    logic [4:0]       op_a_q, op_a_d;
    logic [4:0]       op_b_q, op_b_d;
    logic             correct_q, correct_d;
    logic             sub_prev_q, sub_prev_d;
    logic [7:0]       disp_q, disp_d;
    logic [6:0]       led_q, led_d;

    logic             sub_edge;
    logic             answer_ok;
    logic [5:0]       sum_q, sum_d;
    logic [3:0]       rnd_inc;

`ifdef MATH_GAME_TIMEOUT_EN
    localparam int WIN_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TIMEOUT_CYCLES - 1);
    logic [WIN_W-1:0] win_q, win_d;
`endif

    // ---------------- state / datapath register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rnd_q      <= '0;
            score_q    <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            correct_q  <= 1'b0;
            sub_prev_q <= 1'b0;
            disp_q     <= '0;
            led_q      <= '0;
`ifdef MATH_GAME_TIMEOUT_EN
            win_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rnd_q      <= rnd_d;
            score_q    <= score_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            correct_q  <= correct_d;
            sub_prev_q <= sub_prev_d;
            disp_q     <= disp_d;
            led_q      <= led_d;
`ifdef MATH_GAME_TIMEOUT_EN
            win_q      <= win_d;
`endif
        end
    end

    // ---------------- next-state / datapath ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rnd_d      = rnd_q;
        score_d    = score_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        correct_d  = correct_q;
        // History follows the pin in every state, so a press that started
        // before WAIT_ANS never looks like a fresh edge.
        sub_prev_d = submit;
        sub_edge   = submit & ~sub_prev_q;
        sum_q      = 6'(op_a_q) + 6'(op_b_q);
        answer_ok  = (switch == {2'b00, sum_q});
        rnd_inc    = rnd_q + 4'd1;
`ifdef MATH_GAME_TIMEOUT_EN
        win_d      = win_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD_A;
                    score_d = '0;
                    rnd_d   = '0;
                end
            end
            S_LOAD_A: begin
                op_a_d  = lfsr_in;
                cnt_d   = '0;
                state_d = S_SHOW_A;
            end
            S_SHOW_A: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD_B;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_LOAD_B: begin
                op_b_d  = lfsr_in;
                cnt_d   = '0;
                state_d = S_SHOW_B;
            end
            S_SHOW_B: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
`ifdef MATH_GAME_TIMEOUT_EN
                    win_d   = '0;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                // A press in the last window cycle is checked first, so it
                // beats the timeout.
                if (sub_edge) begin
                    correct_d = answer_ok;
                    if (answer_ok && (score_q != 4'd15))
                        score_d = score_q + 4'd1;
                    cnt_d   = '0;
                    state_d = S_RESULT;
                end
`ifdef MATH_GAME_TIMEOUT_EN
                else if (win_q == WIN_LAST) begin
                    correct_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_RESULT;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
`endif
            end
            S_RESULT: begin
                if (cnt_q == RESULT_LAST) begin
                    cnt_d   = '0;
                    rnd_d   = rnd_inc;
                    state_d = (rnd_inc == ROUNDS_L) ? S_DONE : S_LOAD_A;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    // Decoded from the next state so the registered outputs change on the
    // same edge as the state they describe.
    always_comb begin
        disp_d = '0;
        led_d  = '0;
        sum_d  = 6'(op_a_d) + 6'(op_b_d);
        case (state_d)
            S_SHOW_A: disp_d = {3'b000, op_a_d};
            S_SHOW_B: disp_d = {3'b000, op_b_d};
            S_WAIT:   led_d  = {3'b000, rnd_d + 4'd1};
            S_RESULT: begin
                disp_d = {2'b00, sum_d};
                led_d  = {correct_d, ~correct_d, 1'b0, rnd_d + 4'd1};
            end
            S_DONE: begin
                disp_d = {4'b0000, score_d};
                led_d  = 7'h7F;
            end
            default: begin
                disp_d = '0;
                led_d  = '0;
            end
        endcase
    end

    assign disp_value = disp_q;
    assign led        = led_q;
    assign score      = score_q;
    assign state      = state_q;

endmodule

// File: tb/tb_math_game_ctrl.sv
module tb_math_game_ctrl;

    localparam int SHOW = 4;
    localparam int RES  = 3;
    localparam int TMO  = 10;
    localparam int NR   = 2;
`ifdef MATH_GAME_TIMEOUT_EN
    localparam bit TMO_BUILD = 1'b1;
`else
    localparam bit TMO_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, submit;
    logic [7:0] switch;
    logic [4:0] lfsr_in;
    logic [7:0] disp_value;
    logic [6:0] led;
    logic [3:0] score;
    logic [2:0] state;

    always #5 clk = ~clk;

    math_game_ctrl #(
        .SHOW_CYCLES(SHOW), .RESULT_CYCLES(RES), .TIMEOUT_CYCLES(TMO), .ROUNDS(NR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .submit(submit), .switch(switch),
        .lfsr_in(lfsr_in), .disp_value(disp_value), .led(led), .score(score),
        .state(state)
    );

    // Expected visit to a state: what the outputs must read while there,
    // and how many cycles it must last (0 = not checked).
    typedef struct { int st; int disp; int led; int score; int dur; } rec_t;
    typedef struct { int a; int b; int sw; bit held; int d; bit tmo; bit rst_mid; } rp_t;

    rec_t exp_q[$];
    rp_t  rp[NR];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   m_score;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    task automatic push(input int st, input int disp, input int ld, input int sc, input int dur);
        rec_t r;
        r.st = st; r.disp = disp; r.led = ld; r.score = sc; r.dur = dur;
        exp_q.push_back(r);
    endtask

    function automatic rp_t mk(input int a, input int b, input bit corr, input bit held,
                               input int d, input bit tmo, input bit rm);
        rp_t p;
        p.a = a; p.b = b; p.held = held; p.d = d; p.tmo = tmo; p.rst_mid = rm;
        p.sw = corr ? (a + b) : ((a + b + int'($urandom_range(1, 255))) % 256);
        return p;
    endfunction

    // Reference model of one round, straight from the game rules.
    task automatic push_round(input int r);
        int rn, sum;
        bit ok;
        rn  = r + 1;
        sum = rp[r].a + rp[r].b;
        push(1, 0, 0, m_score, 1);
        push(2, rp[r].a, 0, m_score, SHOW);
        push(3, 0, 0, m_score, 1);
        push(4, rp[r].b, 0, m_score, SHOW);
        if (rp[r].rst_mid) begin
            push(5, 0, rn, m_score, 0);
            return;
        end
        push(5, 0, rn, m_score, rp[r].tmo ? TMO : rp[r].d + 1);
        ok = !rp[r].tmo && (rp[r].sw == sum);
        if (ok && m_score < 15) m_score++;
        push(6, sum, (ok ? 64 : 32) + rn, m_score, RES);
    endtask

    task automatic push_next(input int r);
        if (r + 1 < NR) push_round(r + 1);
        else push(7, m_score, 127, m_score, 0);
    endtask

    task automatic tick();
        @(negedge clk);
        lfsr_in = 5'($urandom_range(1, 31));
    endtask

    task automatic wait_state(input int st);
        for (int i = 0; i < 3000; i++) begin
            if (int'(state) == st) return;
            tick();
        end
        n_cmp++;
        n_bad++;
        $display("FAIL wait_state: state %0d, required %0d within 3000 cycles", state, st);
        summary();
        $finish;
    endtask

    task automatic play_game();
        m_score = 0;
        push_round(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            wait_state(1);
            lfsr_in = 5'(rp[r].a);
            tick();
            start = 1'b1;   // both ignored while showing operand A
            submit = 1'b1;
            tick();
            start = 1'b0;
            submit = 1'b0;
            wait_state(3);
            lfsr_in = 5'(rp[r].b);
            tick();
            wait_state(4);
            if (rp[r].held) submit = 1'b1;
            wait_state(5);
            if (rp[r].rst_mid) begin
                repeat (2) tick();
                push(0, 0, 0, 0, 0);
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_score = 0;
                return;
            end
            if (rp[r].tmo) begin
                push_next(r);
            end else begin
                if (rp[r].held) begin
                    repeat (rp[r].d - 1) tick();
                    submit = 1'b0;
                    tick();
                end else begin
                    repeat (rp[r].d) tick();
                end
                switch = 8'(rp[r].sw);
                submit = 1'b1;
                push_next(r);
                tick();
                submit = 1'b0;
            end
        end
        wait_state(7);
        repeat (3) tick();
    endtask

    // Monitor: every state change presents a new visit; pop and compare.
    initial begin
        rec_t cur;
        bit have;
        int cnt;
        logic [2:0] prev;
        have = 1'b0;
        cnt = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (!have || state != prev) begin
                    if (have && cur.dur != 0)
                        chk($sformatf("duration_state%0d", prev), cnt, cur.dur);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_entry: got state %0d, required none", state);
                        have = 1'b0;
                    end else begin
                        cur = exp_q.pop_front();
                        have = 1'b1;
                    end
                    cnt = 0;
                end
                cnt++;
                if (have) begin
                    chk("state", int'(state), cur.st);
                    chk($sformatf("disp_st%0d", cur.st), int'(disp_value), cur.disp);
                    chk($sformatf("led_st%0d", cur.st), int'(led), cur.led);
                    chk($sformatf("score_st%0d", cur.st), int'(score), cur.score);
                end
                prev = state;
            end
        end
    end

    initial begin
        #500000;
        n_cmp++;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        summary();
        $finish;
    end

    initial begin
        rst = 1'b1; start = 1'b0; submit = 1'b0; switch = '0; lfsr_in = 5'd1;
        repeat (3) tick();
        chk("reset_state", int'(state), 0);
        chk("reset_disp", int'(disp_value), 0);
        chk("reset_led", int'(led), 0);
        chk("reset_score", int'(score), 0);
        rst = 1'b0;
        push(0, 0, 0, 0, 0);
        mon_en = 1'b1;
        tick();
        submit = 1'b1;   // ignored in IDLE
        tick();
        submit = 1'b0;
        repeat (3) tick();

        // Directed game: 5+9 answered right, then 5+9 answered 13 with the
        // button held from SHOW_B into the answer window.
        rp[0] = mk(5, 9, 1'b1, 1'b0, 2, 1'b0, 1'b0);
        rp[1] = mk(5, 9, 1'b0, 1'b1, 3, 1'b0, 1'b0);
        rp[1].sw = 13;
        play_game();

        // Window boundaries: timeout (or a very long wait), then a press on
        // the last window cycle.
        if (TMO_BUILD)
            rp[0] = mk($urandom_range(1, 31), $urandom_range(1, 31), 1'b1, 1'b0, 0, 1'b1, 1'b0);
        else
            rp[0] = mk($urandom_range(1, 31), $urandom_range(1, 31), 1'b1, 1'b0, 1000, 1'b0, 1'b0);
        rp[1] = mk($urandom_range(1, 31), $urandom_range(1, 31), 1'b1, 1'b0, 9, 1'b0, 1'b0);
        play_game();

        for (int g = 0; g < 4; g++) begin
            for (int r = 0; r < NR; r++) begin
                bit t, h;
                t = TMO_BUILD && ($urandom_range(0, 3) == 0);
                h = !t && ($urandom_range(0, 1) == 1);
                rp[r] = mk($urandom_range(1, 31), $urandom_range(1, 31),
                           $urandom_range(0, 1) == 1, h,
                           h ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 9)),
                           t, 1'b0);
            end
            play_game();
        end

        // Reset while waiting for the second answer with score 1.
        rp[0] = mk($urandom_range(1, 31), $urandom_range(1, 31), 1'b1, 1'b0, 1, 1'b0, 1'b0);
        rp[1] = mk($urandom_range(1, 31), $urandom_range(1, 31), 1'b1, 1'b0, 0, 1'b0, 1'b1);
        play_game();

        repeat (5) tick();
        chk("queue_empty", exp_q.size(), 0);
        summary();
        $finish;
    end

endmodule

// File: doc/math_game_ctrl.md
MATH_GAME_CTRL -- requirements
Module: math_game_ctrl

Interface
REQ-001 Parameter SHOW_CYCLES, default 50_000_000: number of cycles each operand stays displayed.
REQ-002 Parameter RESULT_CYCLES, default 50_000_000: number of cycles the result is displayed.
REQ-003 Parameter TIMEOUT_CYCLES, default 500_000_000: answer-window length in cycles.
REQ-004 Parameter ROUNDS, default 8: number of rounds per game, legal range 1..15.
REQ-005 clk  input  1: single clock; all logic SHALL be on its rising edge.
REQ-006 rst  input  1: reset, synchronous, active-high.
REQ-007 start  input  1: level; begins a game.
REQ-008 submit  input  1: answer button; only its rising edge SHALL be acted on.
REQ-009 switch  input  8: player's binary answer.
REQ-010 lfsr_in  input  5: value from the free-running 5-bit LFSR, 1..31.
REQ-011 disp_value  output  8: binary value for the BCD converter.
REQ-012 led  output  7: status LEDs.
REQ-013 score  output  4: number of correct answers in the current game.
REQ-014 state  output  3: current FSM state.

Function
REQ-015 State encodings SHALL be: IDLE=0, LOAD_A=1, SHOW_A=2, LOAD_B=3, SHOW_B=4, WAIT_ANS=5, RESULT=6, DONE=7.
REQ-016 All outputs SHALL be registered.
REQ-017 IDLE: disp_value=0, led=0; start=1 -> LOAD_A, and score and round count cleared.
REQ-018 LOAD_A (1 cycle): op_a<=lfsr_in; -> SHOW_A.
REQ-019 SHOW_A: disp_value={3'b000,op_a} for exactly SHOW_CYCLES cycles; -> LOAD_B.
REQ-020 LOAD_B (1 cycle): op_b<=lfsr_in; -> SHOW_B.
REQ-021 SHOW_B: disp_value={3'b000,op_b} for SHOW_CYCLES cycles; -> WAIT_ANS.
REQ-022 WAIT_ANS: disp_value=0, led[3:0]=round number (1-based), window counter cleared on entry.
REQ-023 Submit edge in WAIT_ANS: correct = (switch == {2'b00, op_a+op_b}), with a 6-bit sum and no overflow possible (max 62); -> RESULT.
REQ-024 Correct answer: score increments, saturating at 15.
REQ-025 RESULT: disp_value = op_a+op_b (zero-extended); led[6]=correct, led[5]=~correct, led[3:0]=round number; held for RESULT_CYCLES cycles.
REQ-026 RESULT exit: increment the round count; if it equals ROUNDS -> DONE, else -> LOAD_A.
REQ-027 DONE: disp_value={4'b0,score}, led=7'h7F; start=1 -> LOAD_A with score and round count cleared.
REQ-028 start SHALL be ignored outside IDLE and DONE.
REQ-029 A submit edge outside WAIT_ANS SHALL be ignored, and SHALL NOT be remembered.
REQ-030 The submit edge detector SHALL track submit in every state, so a button held across entry to WAIT_ANS does not count.
REQ-031 Operands SHALL be captured only in LOAD_A and LOAD_B; changes on lfsr_in elsewhere SHALL have no effect.

Reset
REQ-032 rst=1 at a clock edge SHALL force, in any state including mid-game: state=IDLE, disp_value=0, led=0, score=0, op_a=op_b=0, all counters 0, and edge-detector history=0.
REQ-033 rst SHALL have priority over every other input.

Configuration
REQ-034 With MATH_GAME_TIMEOUT_EN defined, WAIT_ANS with no submit edge for TIMEOUT_CYCLES cycles SHALL go to RESULT with correct=0.
REQ-035 With MATH_GAME_TIMEOUT_EN defined, a submit edge in the final window cycle SHALL win over the timeout.
REQ-036 Without MATH_GAME_TIMEOUT_EN, WAIT_ANS SHALL wait indefinitely and no window counter SHALL be synthesised.

Verification (SHOW_CYCLES=4, RESULT_CYCLES=3, TIMEOUT_CYCLES=10, ROUNDS=2)
REQ-037 Reset then start=1 with lfsr_in=5 at LOAD_A and 9 at LOAD_B -> disp_value=5 for 4 cycles, then disp_value=9 for 4 cycles, then state=5.
REQ-038 In WAIT_ANS, switch=14 and a submit pulse -> state=6, disp_value=14, led[6]=1, score=1; after 3 cycles state=1.
REQ-039 switch=13 and submit -> led[5]=1, score unchanged; after the second round state=7, disp_value=score, led=7'h7F.
REQ-040 Timeout build: no submit for 10 cycles -> RESULT with led[5]=1; submit on cycle 10 -> the answer is evaluated instead. Non-timeout build: state stays 5 after 1000 cycles.
REQ-041 Submit held high from SHOW_B into WAIT_ANS -> no evaluation until release and re-press; start pulses during SHOW_A are ignored.
REQ-042 rst asserted in WAIT_ANS with score=1 -> next cycle state=0, score=0, disp_value=0, led=0.
